// File: rtl/gpio_in.sv
// GPIO input peripheral: 2-FF synchroniser, optional inversion, per-bit debounce,
// sticky W1C edge flags and a level interrupt on the simple peripheral bus.
module gpio_in #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned INVERT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    input  logic             we,
    input  logic [WIDTH-1:0] pins,
    output logic [31:0]      q,
    output logic             irq
);

    localparam int unsigned      CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [WIDTH-1:0] IDLE     = (INVERT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    localparam logic [7:0] A_DATA   = 8'h00;
    localparam logic [7:0] A_RISE   = 8'h04;
    localparam logic [7:0] A_FALL   = 8'h08;
    localparam logic [7:0] A_IRQ_EN = 8'h0C;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_db;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;

    logic [WIDTH-1:0] w_cond;
    logic [WIDTH-1:0] w_db_next;
    logic [CW-1:0]    w_cnt_next [WIDTH];
    logic [WIDTH-1:0] w_rise_set;
    logic [WIDTH-1:0] w_fall_set;
    logic [WIDTH-1:0] w_rise_clr;
    logic [WIDTH-1:0] w_fall_clr;
    logic [31:0]      w_bemask;
    logic [31:0]      w_wmask_data;
    logic             w_wr_rise;
    logic             w_wr_fall;
    logic             w_wr_en;
    logic             w_unused;

    assign w_cond = (INVERT != 0) ? ~r_s2 : r_s2;

    // Debounce: the counter only advances while the conditioned input disagrees
    // with DB, so any agreeing sample restarts the stability window.
    always_comb begin
        w_db_next = r_db;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_cnt_next[i] = '0;
            if (w_cond[i] != r_db[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_db_next[i] = w_cond[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_rise_set = w_db_next & ~r_db;
    assign w_fall_set = ~w_db_next & r_db;

    assign w_bemask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign w_wmask_data = wdata & w_bemask;
    assign w_wr_rise    = we && (addr == A_RISE);
    assign w_wr_fall    = we && (addr == A_FALL);
    assign w_wr_en      = we && (addr == A_IRQ_EN);
    assign w_rise_clr   = w_wr_rise ? w_wmask_data[WIDTH-1:0] : '0;
    assign w_fall_clr   = w_wr_fall ? w_wmask_data[WIDTH-1:0] : '0;
    assign w_unused     = ^wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= IDLE;
            r_s2      <= IDLE;
            r_db      <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= pins;
            r_s2 <= r_s1;
            r_db <= w_db_next;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            // Set is ORed in after the clear so a same-cycle edge survives W1C.
            r_rise <= (r_rise & ~w_rise_clr) | w_rise_set;
            r_fall <= (r_fall & ~w_fall_clr) | w_fall_set;
            if (w_wr_en) begin
                r_rise_en <= (r_rise_en & ~w_bemask[WIDTH-1:0])
                           | w_wmask_data[WIDTH-1:0];
                r_fall_en <= (r_fall_en & ~w_bemask[16+WIDTH-1:16])
                           | w_wmask_data[16+WIDTH-1:16];
            end
        end
    end

    always_comb begin
        q = '0;
        case (addr)
            A_DATA:   q[WIDTH-1:0] = r_db;
            A_RISE:   q[WIDTH-1:0] = r_rise;
            A_FALL:   q[WIDTH-1:0] = r_fall;
            A_IRQ_EN: begin
                q[WIDTH-1:0]       = r_rise_en;
                q[16+WIDTH-1:16]   = r_fall_en;
            end
            default:  q = '0;
        endcase
    end

    assign irq = (|(r_rise & r_rise_en)) | (|(r_fall & r_fall_en));

endmodule
